// File: rtl/keycode_sender.sv
// Transmit side of the digit-entry key bus: sends a stored CODE_LEN-digit code one digit per beat.
// Optional trailer beat carrying the digit sum mod 10 is enabled by defining KEYCODE_SENDER_CHECKSUM_EN.
module keycode_sender #(
    parameter int          CODE_LEN   = 6,
    parameter int          GAP_CYCLES = 0,
    parameter logic [3:0]  IDLE_KEY   = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       code_wr,
    input  logic [2:0] code_idx,
    input  logic [3:0] code_data,
    output logic [3:0] key_out,
    output logic       key_valid,
    output logic       busy,
    output logic       done
);

    localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

    typedef enum logic [2:0] {IDLE, SEND, GAP, TRAIL, FIN} state_t;

`ifdef KEYCODE_SENDER_CHECKSUM_EN
    localparam state_t AFTER_LAST = TRAIL;
`else
    localparam state_t AFTER_LAST = FIN;
`endif

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       code [CODE_LEN];
    logic [3:0]       digit_sel;
    logic [3:0]       checksum;
    logic             last_digit;
    logic             gap_end;

    logic [3:0] key_d;
    logic       valid_d, busy_d, done_d;

    function automatic logic [3:0] default_digit(input int i);
        case (i)
            0, 1:    return 4'd3;
            2, 4:    return 4'd5;
            3:       return 4'd2;
            5:       return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    assign last_digit = (idx == LAST_IDX);
    assign gap_end    = (32'(gap_cnt) == GAP_CYCLES - 1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                idx_next = '0;
                if (start && !abort) state_next = SEND;
            end
            SEND: begin
                if (abort)                state_next = IDLE;
                else if (GAP_CYCLES > 0)  state_next = GAP;
                else if (last_digit)      state_next = AFTER_LAST;
                else begin
                    state_next = SEND;
                    idx_next   = idx + 1'b1;
                end
            end
            GAP: begin
                if (abort) state_next = IDLE;
                else if (gap_end) begin
                    if (last_digit) state_next = AFTER_LAST;
                    else begin
                        state_next = SEND;
                        idx_next   = idx + 1'b1;
                    end
                end
            end
            TRAIL:   state_next = abort ? IDLE : FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: outputs are computed from the upcoming state and registered
    always_comb begin
        digit_sel = IDLE_KEY;
        for (int i = 0; i < CODE_LEN; i++)
            if (idx_next == IDX_W'(i)) digit_sel = code[i];

        key_d   = IDLE_KEY;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_next)
            SEND:  begin key_d = digit_sel; valid_d = 1'b1; busy_d = 1'b1; end
            GAP:   busy_d = 1'b1;
            TRAIL: begin key_d = checksum;  valid_d = 1'b1; busy_d = 1'b1; end
            FIN:   done_d = 1'b1;
            default: ;
        endcase
    end

`ifdef KEYCODE_SENDER_CHECKSUM_EN
    logic [6:0] digit_sum;
    always_comb begin
        digit_sum = '0;
        for (int i = 0; i < CODE_LEN; i++) digit_sum = digit_sum + 7'(code[i]);
        checksum = 4'(digit_sum % 7'd10);
    end
`else
    assign checksum = IDLE_KEY;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_out   <= IDLE_KEY;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            key_out   <= key_d;
            key_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) gap_cnt <= '0;
        else if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
        else gap_cnt <= '0;
    end

    // Code store: writable only while idle so a sequence always sends a stable code
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this small store is reset on purpose; reset must restore the default code.
            for (int i = 0; i < CODE_LEN; i++) code[i] <= default_digit(i);
        end else if (code_wr && state == IDLE) begin
            for (int i = 0; i < CODE_LEN; i++)
                if (code_idx == 3'(i)) code[i] <= code_data;
        end
    end

endmodule

// File: tb/tb_keycode_sender.sv
// Directed self-checking bench for keycode_sender (zero-gap and two-gap instances).
// Trailer expectations follow KEYCODE_SENDER_CHECKSUM_EN when it is defined.
module tb_keycode_sender;

    typedef logic [5:0][3:0] digits_t;

    logic       clk = 1'b0;
    logic       reset, start, abort, code_wr, g_start;
    logic [2:0] code_idx;
    logic [3:0] code_data;
    logic [3:0] key_out, g_key;
    logic       key_valid, busy, done, g_valid, g_busy, g_done;
    logic       g_zero = 1'b0;
    logic [2:0] g_idx = 3'd0;
    logic [3:0] g_data = 4'd0;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    keycode_sender #(.CODE_LEN(6), .GAP_CYCLES(0), .IDLE_KEY(4'hF)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .code_wr(code_wr), .code_idx(code_idx), .code_data(code_data),
        .key_out(key_out), .key_valid(key_valid), .busy(busy), .done(done)
    );

    keycode_sender #(.CODE_LEN(6), .GAP_CYCLES(2), .IDLE_KEY(4'hF)) dut_gap (
        .clk(clk), .reset(reset), .start(g_start), .abort(g_zero),
        .code_wr(g_zero), .code_idx(g_idx), .code_data(g_data),
        .key_out(g_key), .key_valid(g_valid), .busy(g_busy), .done(g_done)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic digits_t mk(input int a0, a1, a2, a3, a4, a5);
        digits_t d;
        d[0] = 4'(a0); d[1] = 4'(a1); d[2] = 4'(a2);
        d[3] = 4'(a3); d[4] = 4'(a4); d[5] = 4'(a5);
        return d;
    endfunction

    function automatic logic [3:0] sum_mod10(input digits_t d);
        int s = 0;
        for (int i = 0; i < 6; i++) s += int'(d[i]);
        return 4'(s % 10);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_key"}, 8'(key_out), 8'hF);
        check({tag, "_valid"}, 8'(key_valid), 8'd0);
        check({tag, "_busy"}, 8'(busy), 8'd0);
    endtask

    // Full sequence on the zero-gap instance; disturb pulses start and a code write mid-sequence
    task automatic run_seq(input digits_t exp, input string tag, input bit disturb);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_d%0d_key", tag, i), 8'(key_out), 8'(exp[i]));
            check($sformatf("%s_d%0d_valid", tag, i), 8'(key_valid), 8'd1);
            check($sformatf("%s_d%0d_busy", tag, i), 8'(busy), 8'd1);
            check($sformatf("%s_d%0d_done", tag, i), 8'(done), 8'd0);
            if (disturb && i == 1) begin
                start = 1'b1; code_wr = 1'b1; code_idx = 3'd0; code_data = 4'd8;
            end else begin
                start = 1'b0; code_wr = 1'b0;
            end
            step();
        end
`ifdef KEYCODE_SENDER_CHECKSUM_EN
        check({tag, "_trl_key"}, 8'(key_out), 8'(sum_mod10(exp)));
        check({tag, "_trl_valid"}, 8'(key_valid), 8'd1);
        step();
`endif
        check({tag, "_done"}, 8'(done), 8'd1);
        check_idle({tag, "_fin"});
        step();
        check({tag, "_done_clr"}, 8'(done), 8'd0);
        check_idle({tag, "_idle1"});
        step();
        check({tag, "_done_once"}, 8'(done), 8'd0);
        check_idle({tag, "_idle2"});
    endtask

    initial begin
        int busy_cnt;
        digits_t dflt;
        dflt = mk(3, 3, 5, 2, 5, 6);
        reset = 1'b1; start = 1'b0; abort = 1'b0; g_start = 1'b0;
        code_wr = 1'b0; code_idx = 3'd0; code_data = 4'd0;
        #12;
        check_idle("reset");
        check("reset_done", 8'(done), 8'd0);
        reset = 1'b0;

        run_seq(dflt, "dflt", 1'b0);

        // Two idle gap cycles after every digit
        busy_cnt = 0;
        g_start = 1'b1;
        step();
        g_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("gap_d%0d_key", i), 8'(g_key), 8'(dflt[i]));
            check($sformatf("gap_d%0d_valid", i), 8'(g_valid), 8'd1);
            busy_cnt += int'(g_busy);
            step();
            for (int g = 0; g < 2; g++) begin
                check($sformatf("gap_d%0d_g%0d_key", i, g), 8'(g_key), 8'hF);
                check($sformatf("gap_d%0d_g%0d_valid", i, g), 8'(g_valid), 8'd0);
                check($sformatf("gap_d%0d_g%0d_done", i, g), 8'(g_done), 8'd0);
                busy_cnt += int'(g_busy);
                step();
            end
        end
`ifdef KEYCODE_SENDER_CHECKSUM_EN
        check("gap_trl_key", 8'(g_key), 8'(sum_mod10(dflt)));
        busy_cnt += int'(g_busy);
        step();
        check("gap_busy_total", 8'(busy_cnt), 8'd19);
`else
        check("gap_busy_total", 8'(busy_cnt), 8'd18);
`endif
        check("gap_done", 8'(g_done), 8'd1);
        check("gap_fin_busy", 8'(g_busy), 8'd0);
        step();
        check("gap_done_clr", 8'(g_done), 8'd0);

        // Abort during the third digit
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("abort_d2_key", 8'(key_out), 8'd5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort");
        check("abort_done", 8'(done), 8'd0);
        step();
        check("abort_no_done", 8'(done), 8'd0);
        run_seq(dflt, "after_abort", 1'b0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check_idle("start_abort");
        step();
        check_idle("start_abort2");

        // Code programming, out-of-range write ignored
        for (int i = 0; i < 6; i++) begin
            code_wr = 1'b1; code_idx = 3'(i); code_data = 4'(i + 1);
            step();
        end
        code_idx = 3'd7; code_data = 4'd9;
        step();
        code_wr = 1'b0;
        run_seq(mk(1, 2, 3, 4, 5, 6), "prog", 1'b1);
        run_seq(mk(1, 2, 3, 4, 5, 6), "prog_stable", 1'b0);

        // Asynchronous reset mid-sequence restores outputs and default code
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("arst_pre_valid", 8'(key_valid), 8'd1);
        #3 reset = 1'b1;
        #1;
        check_idle("arst");
        #1 reset = 1'b0;
        step();
        run_seq(dflt, "post_reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
